// File: rtl/uart_cmd_sequencer_if.sv
// Signal bundle between uart_cmd_sequencer and its UART/modulator neighbours.
// The slave modport is the sequencer's view; master is the surrounding logic/bench.
interface uart_cmd_sequencer_if;
  logic        rx_done;
  logic [7:0]  data_received;
  logic        parity_error;
  logic        tx_busy;
  logic        sync_pulse;
  logic        start_tx;
  logic [7:0]  data_to_tx;
  logic [11:0] angle;
  logic        angle_update;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  modport slave (
    input  rx_done, data_received, parity_error, tx_busy, sync_pulse,
    output start_tx, data_to_tx, angle, angle_update, frame_ok, frame_err, err_count
  );

  modport master (
    output rx_done, data_received, parity_error, tx_busy, sync_pulse,
    input  start_tx, data_to_tx, angle, angle_update, frame_ok, frame_err, err_count
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Two-byte UART command framer with range check, shadowed angle applied on sync_pulse.
// Define UART_CMD_ACK_EN to acknowledge each frame over uart_tx and enable QUERY.
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter logic [11:0] ANGLE_MAX      = 12'd3599,
  parameter logic [7:0]  ACK_OK         = 8'hA5,
  parameter logic [7:0]  ACK_ERR        = 8'hEE
) (
  input logic                  clk,
  input logic                  reset,
  uart_cmd_sequencer_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_ACK_EN
  typedef enum logic [2:0] {StWaitHi, StWaitLo, StCheck, StTxReq, StTxWait} state_e;
`else
  typedef enum logic [2:0] {StWaitHi, StWaitLo, StCheck} state_e;
`endif

  state_e        state_q;
  logic          rx_done_q;
  logic [7:0]    byte1_q;
  logic [11:0]   new_angle_q;
  logic          accept_q;
  logic [TW-1:0] timer_q;
  logic [11:0]   shadow_q;
  logic          pending_q;
  logic [11:0]   angle_q;
  logic          angle_update_q;
  logic          frame_ok_q;
  logic          frame_err_q;
  logic [7:0]    err_count_q;

  logic        strobe;
  logic [11:0] rx_angle;
  logic        cmd_set;
  logic        cmd_query;
  logic        frame_good;
  logic        ok_evt;
  logic        err_evt;
  logic        apply;
  logic        commit;

  assign strobe    = bus.rx_done & ~rx_done_q;
  assign rx_angle  = {byte1_q[3:0], bus.data_received};
  assign cmd_set   = (byte1_q[7:4] == 4'h1);
`ifdef UART_CMD_ACK_EN
  assign cmd_query = (byte1_q[7:4] == 4'h2);
`else
  assign cmd_query = 1'b0;
`endif
  assign frame_good = (cmd_set | cmd_query) && (rx_angle <= ANGLE_MAX);
  assign apply      = bus.sync_pulse & pending_q;
  assign commit     = (state_q == StCheck) & accept_q & cmd_set;

  // The verdict is formed while byte 2 arrives so the strobes land one cycle after it.
  always_comb begin
    ok_evt  = 1'b0;
    err_evt = 1'b0;
    unique case (state_q)
      StWaitHi: err_evt = strobe & bus.parity_error;
      StWaitLo: begin
        if (strobe) begin
          ok_evt  = ~bus.parity_error & frame_good;
          err_evt = bus.parity_error | ~frame_good;
        end else begin
          err_evt = (timer_q == TMAX);
        end
      end
      default: err_evt = strobe;
    endcase
  end

`ifdef UART_CMD_ACK_EN
  logic       start_tx_q;
  logic [7:0] data_to_tx_q;
  logic       tx_idx_q;
  logic       busy_seen_q;
  assign bus.start_tx   = start_tx_q;
  assign bus.data_to_tx = data_to_tx_q;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = bus.tx_busy;
  assign bus.start_tx   = 1'b0;
  assign bus.data_to_tx = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StWaitHi;
      rx_done_q      <= 1'b0;
      byte1_q        <= 8'h00;
      new_angle_q    <= 12'h000;
      accept_q       <= 1'b0;
      timer_q        <= '0;
      shadow_q       <= 12'h000;
      pending_q      <= 1'b0;
      angle_q        <= 12'h000;
      angle_update_q <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      err_count_q    <= 8'h00;
`ifdef UART_CMD_ACK_EN
      start_tx_q     <= 1'b0;
      data_to_tx_q   <= 8'h00;
      tx_idx_q       <= 1'b0;
      busy_seen_q    <= 1'b0;
`endif
    end else begin
      rx_done_q   <= bus.rx_done;
      frame_ok_q  <= ok_evt;
      frame_err_q <= err_evt;
      if (err_evt && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'h01;

      // Apply uses the shadow as it stood before any same-cycle commit.
      angle_update_q <= apply;
      if (apply) angle_q <= shadow_q;
      if (commit) shadow_q <= new_angle_q;
      pending_q <= commit | (pending_q & ~apply);

`ifdef UART_CMD_ACK_EN
      start_tx_q <= 1'b0;
`endif
      unique case (state_q)
        StWaitHi: begin
          if (strobe && !bus.parity_error) begin
            byte1_q <= bus.data_received;
            timer_q <= '0;
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (strobe) begin
            if (bus.parity_error) begin
              state_q <= StWaitHi;
            end else begin
              new_angle_q <= rx_angle;
              accept_q    <= ok_evt;
              state_q     <= StCheck;
            end
          end else if (timer_q == TMAX) begin
            state_q <= StWaitHi;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`ifdef UART_CMD_ACK_EN
        StCheck: begin
          tx_idx_q <= 1'b0;
          state_q  <= StTxReq;
        end
        StTxReq: begin
          if (!bus.tx_busy) begin
            start_tx_q  <= 1'b1;
            busy_seen_q <= 1'b0;
            state_q     <= StTxWait;
            if (!accept_q)      data_to_tx_q <= ACK_ERR;
            else if (cmd_query) data_to_tx_q <= tx_idx_q ? angle_q[7:0] : {4'h0, angle_q[11:8]};
            else                data_to_tx_q <= ACK_OK;
          end
        end
        StTxWait: begin
          if (bus.tx_busy) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            if (accept_q && cmd_query && !tx_idx_q) begin
              tx_idx_q <= 1'b1;
              state_q  <= StTxReq;
            end else begin
              state_q <= StWaitHi;
            end
          end
        end
`else
        StCheck: state_q <= StWaitHi;
`endif
        default: state_q <= StWaitHi;
      endcase
    end
  end

  assign bus.angle        = angle_q;
  assign bus.angle_update = angle_update_q;
  assign bus.frame_ok     = frame_ok_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.err_count    = err_count_q;

endmodule
